forward_update_window: RTL and testbench
========================================

FORWARD_UPDATE_WINDOW -- requirements
Module: forward_update_window

Interface
REQ-001 Parameters SHALL be DATA_WIDTH=4 (data width), KEY_WIDTH=2 (key width), HASH_ADR_WIDTH=2 (own-memory address width), SHIFT_HASH_ADR_WIDTH=2 (next-memory address width), DEPTH=2 (window entries, 1..8).
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 clk_en  in  1  stage enable; low freezes all state and outputs.
REQ-005 flush_i  in  1  invalidate all window entries.
REQ-006 wr_en_i  in  1  own-memory write committed this cycle.
REQ-007 wr_hash_adr_i / wr_data_i / wr_key_i / wr_valid_i  in  HASH_ADR_WIDTH / DATA_WIDTH / KEY_WIDTH / 1  written slot contents.
REQ-008 wr_shift_adr_i / wr_shift_valid_i  in  SHIFT_HASH_ADR_WIDTH / 1  shift target stored with the written entry.
REQ-009 nm_wr_en_i / nm_wr_adr_i / nm_wr_valid_i  in  1 / SHIFT_HASH_ADR_WIDTH / 1  next-memory write committed this cycle.
REQ-010 query_hash_adr_i / query_shift_adr_i  in  HASH_ADR_WIDTH / SHIFT_HASH_ADR_WIDTH  addresses of the request being read from memory.
REQ-011 forward_hash_adr_o, forward_data_o, forward_key_o, forward_valid_o, forward_shift_hash_adr_o, forward_shift_valid_o, forward_updated_mem_o  out  per field  youngest matching own-memory write.
REQ-012 forward_next_mem_hash_adr_o, forward_next_mem_valid_o, forward_next_mem_updated_o  out  SHIFT_HASH_ADR_WIDTH / 1 / 1  youngest matching next-memory write.
REQ-013 occupancy_o  out  $clog2(DEPTH+1)  number of valid own-memory entries.

Function
REQ-014 Window SHALL be two DEPTH-entry shift registers (own, next-mem), entry 0 youngest; when clk_en=1 and wr_en_i=1, own entries shift by one, incoming write enters entry 0, entry DEPTH-1 is discarded.
REQ-015 Next-mem window SHALL behave identically, driven by nm_wr_en_i.
REQ-016 clk_en=1 with wr_en_i=0 SHALL leave own window unchanged (no bubble insertion); likewise next-mem.
REQ-017 Lookup SHALL be registered, latency 1: outputs in cycle t+1 reflect query in cycle t against window contents at t plus any write presented in cycle t (write bypass; same-cycle write has highest priority).
REQ-018 Own match: entry hash_adr == query_hash_adr_i and entry occupied; youngest match wins; forward_updated_mem_o=1 and fields copied from it.
REQ-019 No own match: forward_updated_mem_o=0, all other own outputs 0.
REQ-020 Next-mem match compares query_shift_adr_i to nm entries, youngest wins; forward_next_mem_updated_o=1, hash_adr/valid copied; no match: all 0.
REQ-021 Stored wr_valid_i=0 (deletion) SHALL still match and forward valid=0.
REQ-022 flush_i=1 with clk_en=1 SHALL clear all occupied bits and registered outputs next cycle; a simultaneous write SHALL be dropped (flush wins).
REQ-023 occupancy_o SHALL increment per write until DEPTH, saturate at DEPTH, reset to 0 on flush/reset.
REQ-024 clk_en=0 SHALL hold windows, outputs and occupancy regardless of wr_en_i, nm_wr_en_i, flush_i.

Reset
REQ-025 reset=1 at a rising edge SHALL clear all entries' occupied bits, occupancy_o and every output to 0, independent of clk_en; reset overrides flush and writes.
REQ-026 Entry payload fields need not be reset; only occupied bits are.

Structure
REQ-027 A shared package SHALL hold the own-entry struct (hash_adr, key, data, valid, shift_adr, shift_valid, occupied) and next-mem entry struct, parameterized via width constants.
REQ-028 One sub-module, forward_match_select, SHALL implement youngest-match priority selection, instantiated once per window.

Verification
REQ-029 Reset then query adr 1 -> next cycle forward_updated_mem_o=0, occupancy_o=0.
REQ-030 Write adr 2 key 1 data 5 valid 1, next cycle query adr 2 -> forward_updated_mem_o=1, key 1, data 5.
REQ-031 Write adr 3 data 4, then adr 3 data 9, query adr 3 -> data 9 (youngest wins); occupancy_o=2.
REQ-032 Same-cycle write adr 1 data 7 and query adr 1 -> next cycle data 7 (bypass).
REQ-033 DEPTH=2: writes adr 0,1,2 then query adr 0 -> no match (evicted); occupancy_o stays 2.
REQ-034 Flush with concurrent write adr 1, then query adr 1 -> updated 0; clk_en=0 during a write -> window unchanged.

Source files
------------

// File: rtl/forward_update_window_pkg.sv
// -----------------------------------------------------------------------------
// forward_update_window_pkg
//
// Shared types and width constants for the forward update window.
//
// Contents:
//   DATA_W / KEY_W / HASH_ADR_W / SHIFT_ADR_W  field widths of a window entry
//   DEPTH_DEFAULT                               default number of window entries
//   own_entry_t                                 one committed own-memory write
//   nm_entry_t                                  one committed next-memory write
//   own_none() / nm_none()                      all-zero entries ("no match")
//
// In both entry structs the 'occupied' bit sits in the MSB. The match selector
// returns all zeros when nothing hits, so 'occupied' of a selected entry
// doubles as the "match found" flag.
// -----------------------------------------------------------------------------
package forward_update_window_pkg;

    localparam int DATA_W        = 4;
    localparam int KEY_W         = 2;
    localparam int HASH_ADR_W    = 2;
    localparam int SHIFT_ADR_W   = 2;
    localparam int DEPTH_DEFAULT = 2;

    typedef struct packed {
        logic                   occupied;
        logic [HASH_ADR_W-1:0]  hash_adr;
        logic [DATA_W-1:0]      data;
        logic [KEY_W-1:0]       key;
        logic                   valid;
        logic [SHIFT_ADR_W-1:0] shift_adr;
        logic                   shift_valid;
    } own_entry_t;

    typedef struct packed {
        logic                   occupied;
        logic [SHIFT_ADR_W-1:0] hash_adr;
        logic                   valid;
    } nm_entry_t;

    localparam int OWN_ENTRY_W = $bits(own_entry_t);
    localparam int NM_ENTRY_W  = $bits(nm_entry_t);

    function automatic own_entry_t own_none();
        own_entry_t e;
        e = '0;
        return e;
    endfunction

    function automatic nm_entry_t nm_none();
        nm_entry_t e;
        e = '0;
        return e;
    endfunction

endpackage

// File: rtl/forward_match_select.sv
// -----------------------------------------------------------------------------
// forward_match_select
//
// Youngest-match priority selector. Candidate 0 is the youngest, candidate
// N-1 the oldest. The lowest-indexed candidate whose hit bit is set is
// returned; if no hit bit is set the output is all zeros.
//
// Ports:
//   hit   [N]      per-candidate match flags
//   cand  [N] x W  candidate payloads (packed entries)
//   sel   W        selected payload, or '0 when nothing matches
// -----------------------------------------------------------------------------
module forward_match_select #(
    parameter int N = 3,
    parameter int W = 8
) (
    input  logic [N-1:0] hit,
    input  logic [W-1:0] cand [N],
    output logic [W-1:0] sel
);

    // Scan oldest to youngest so that a younger hit overwrites an older one.
    always_comb begin
        sel = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (hit[i]) begin
                sel = cand[i];
            end
        end
    end

endmodule

// File: rtl/forward_update_window.sv
// -----------------------------------------------------------------------------
// forward_update_window
//
// Keeps the last DEPTH own-memory writes and the last DEPTH next-memory writes
// in two shift-register windows (entry 0 youngest) and forwards the youngest
// entry matching the address of the request currently being read. Lookup is
// registered (latency 1); a write presented in the same cycle as the query is
// treated as younger than every stored entry (write bypass).
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   clk_en                     stage enable; low freezes everything
//   flush_i                    drop all window entries (wins over writes)
//   wr_en_i                    own-memory write this cycle
//   wr_hash_adr_i, wr_data_i,
//   wr_key_i, wr_valid_i       written own-memory slot contents
//   wr_shift_adr_i,
//   wr_shift_valid_i           shift target stored with the own entry
//   nm_wr_en_i, nm_wr_adr_i,
//   nm_wr_valid_i              next-memory write this cycle
//   query_hash_adr_i           own-memory address being read
//   query_shift_adr_i          next-memory address being read
//   forward_*_o                youngest matching own entry (0s if none)
//   forward_updated_mem_o      own match found
//   forward_next_mem_*_o       youngest matching next-memory entry (0s if none)
//   occupancy_o                number of occupied own entries (saturates)
//
// The entry structs take their field widths from forward_update_window_pkg;
// the width parameters here must be kept equal to those constants.
// -----------------------------------------------------------------------------
module forward_update_window
    import forward_update_window_pkg::*;
#(
    parameter int DATA_WIDTH           = DATA_W,
    parameter int KEY_WIDTH            = KEY_W,
    parameter int HASH_ADR_WIDTH       = HASH_ADR_W,
    parameter int SHIFT_HASH_ADR_WIDTH = SHIFT_ADR_W,
    parameter int DEPTH                = DEPTH_DEFAULT
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            clk_en,
    input  logic                            flush_i,

    input  logic                            wr_en_i,
    input  logic [HASH_ADR_WIDTH-1:0]       wr_hash_adr_i,
    input  logic [DATA_WIDTH-1:0]           wr_data_i,
    input  logic [KEY_WIDTH-1:0]            wr_key_i,
    input  logic                            wr_valid_i,
    input  logic [SHIFT_HASH_ADR_WIDTH-1:0] wr_shift_adr_i,
    input  logic                            wr_shift_valid_i,

    input  logic                            nm_wr_en_i,
    input  logic [SHIFT_HASH_ADR_WIDTH-1:0] nm_wr_adr_i,
    input  logic                            nm_wr_valid_i,

    input  logic [HASH_ADR_WIDTH-1:0]       query_hash_adr_i,
    input  logic [SHIFT_HASH_ADR_WIDTH-1:0] query_shift_adr_i,

    output logic [HASH_ADR_WIDTH-1:0]       forward_hash_adr_o,
    output logic [DATA_WIDTH-1:0]           forward_data_o,
    output logic [KEY_WIDTH-1:0]            forward_key_o,
    output logic                            forward_valid_o,
    output logic [SHIFT_HASH_ADR_WIDTH-1:0] forward_shift_hash_adr_o,
    output logic                            forward_shift_valid_o,
    output logic                            forward_updated_mem_o,

    output logic [SHIFT_HASH_ADR_WIDTH-1:0] forward_next_mem_hash_adr_o,
    output logic                            forward_next_mem_valid_o,
    output logic                            forward_next_mem_updated_o,

    output logic [$clog2(DEPTH+1)-1:0]      occupancy_o
);

    localparam int                OCC_W   = $clog2(DEPTH + 1);
    localparam logic [OCC_W-1:0]  OCC_MAX = OCC_W'(DEPTH);
    localparam logic [OCC_W-1:0]  OCC_ONE = OCC_W'(1);

    // ------------------------------------------------------------------
    // Incoming entries
    // ------------------------------------------------------------------
    own_entry_t own_wr;
    nm_entry_t  nm_wr;

    always_comb begin
        own_wr             = own_none();
        own_wr.occupied    = 1'b1;
        own_wr.hash_adr    = wr_hash_adr_i;
        own_wr.data        = wr_data_i;
        own_wr.key         = wr_key_i;
        own_wr.valid       = wr_valid_i;
        own_wr.shift_adr   = wr_shift_adr_i;
        own_wr.shift_valid = wr_shift_valid_i;

        nm_wr              = nm_none();
        nm_wr.occupied     = 1'b1;
        nm_wr.hash_adr     = nm_wr_adr_i;
        nm_wr.valid        = nm_wr_valid_i;
    end

    // ------------------------------------------------------------------
    // Window shift registers and occupancy
    // Only the occupied bits are reset; payloads are don't-care while the
    // entry is unoccupied because a hit requires occupied=1.
    // ------------------------------------------------------------------
    own_entry_t       own_q [DEPTH];
    nm_entry_t        nm_q  [DEPTH];
    logic [OCC_W-1:0] occ_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                own_q[i].occupied <= 1'b0;
                nm_q[i].occupied  <= 1'b0;
            end
        end else if (clk_en) begin
            if (flush_i) begin
                for (int i = 0; i < DEPTH; i++) begin
                    own_q[i].occupied <= 1'b0;
                    nm_q[i].occupied  <= 1'b0;
                end
            end else begin
                if (wr_en_i) begin
                    own_q[0] <= own_wr;
                    for (int i = 1; i < DEPTH; i++) begin
                        own_q[i] <= own_q[i-1];
                    end
                end
                if (nm_wr_en_i) begin
                    nm_q[0] <= nm_wr;
                    for (int i = 1; i < DEPTH; i++) begin
                        nm_q[i] <= nm_q[i-1];
                    end
                end
            end
        end
    end

    // Every write pushes an occupied entry in, so occupancy is a saturating
    // write counter rather than a popcount of the occupied bits.
    always_ff @(posedge clk) begin
        if (reset) begin
            occ_q <= '0;
        end else if (clk_en) begin
            if (flush_i) begin
                occ_q <= '0;
            end else if (wr_en_i && (occ_q != OCC_MAX)) begin
                occ_q <= occ_q + OCC_ONE;
            end
        end
    end

    // ------------------------------------------------------------------
    // Match candidates: index 0 is the same-cycle write, index i+1 is
    // window entry i. This puts the bypass path ahead of every stored entry.
    // ------------------------------------------------------------------
    logic [DEPTH:0]         own_hit;
    logic [OWN_ENTRY_W-1:0] own_cand [DEPTH+1];
    logic [DEPTH:0]         nm_hit;
    logic [NM_ENTRY_W-1:0]  nm_cand  [DEPTH+1];

    always_comb begin
        own_hit     = '0;
        nm_hit      = '0;
        own_hit[0]  = wr_en_i && (wr_hash_adr_i == query_hash_adr_i);
        own_cand[0] = own_wr;
        nm_hit[0]   = nm_wr_en_i && (nm_wr_adr_i == query_shift_adr_i);
        nm_cand[0]  = nm_wr;
        for (int i = 0; i < DEPTH; i++) begin
            own_hit[i+1]  = own_q[i].occupied && (own_q[i].hash_adr == query_hash_adr_i);
            own_cand[i+1] = own_q[i];
            nm_hit[i+1]   = nm_q[i].occupied && (nm_q[i].hash_adr == query_shift_adr_i);
            nm_cand[i+1]  = nm_q[i];
        end
    end

    logic [OWN_ENTRY_W-1:0] own_sel;
    logic [NM_ENTRY_W-1:0]  nm_sel;

    forward_match_select #(
        .N (DEPTH + 1),
        .W (OWN_ENTRY_W)
    ) u_own_select (
        .hit  (own_hit),
        .cand (own_cand),
        .sel  (own_sel)
    );

    forward_match_select #(
        .N (DEPTH + 1),
        .W (NM_ENTRY_W)
    ) u_nm_select (
        .hit  (nm_hit),
        .cand (nm_cand),
        .sel  (nm_sel)
    );

    // ------------------------------------------------------------------
    // Registered lookup result. The selected entry's occupied bit is the
    // "updated" flag, since the selector yields zeros on a miss.
    // ------------------------------------------------------------------
    own_entry_t own_out_q;
    nm_entry_t  nm_out_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            own_out_q <= own_none();
            nm_out_q  <= nm_none();
        end else if (clk_en) begin
            if (flush_i) begin
                own_out_q <= own_none();
                nm_out_q  <= nm_none();
            end else begin
                own_out_q <= own_entry_t'(own_sel);
                nm_out_q  <= nm_entry_t'(nm_sel);
            end
        end
    end

    assign forward_updated_mem_o       = own_out_q.occupied;
    assign forward_hash_adr_o          = own_out_q.hash_adr;
    assign forward_data_o              = own_out_q.data;
    assign forward_key_o               = own_out_q.key;
    assign forward_valid_o             = own_out_q.valid;
    assign forward_shift_hash_adr_o    = own_out_q.shift_adr;
    assign forward_shift_valid_o       = own_out_q.shift_valid;

    assign forward_next_mem_updated_o  = nm_out_q.occupied;
    assign forward_next_mem_hash_adr_o = nm_out_q.hash_adr;
    assign forward_next_mem_valid_o    = nm_out_q.valid;

    assign occupancy_o                 = occ_q;

endmodule

// File: tb/tb_forward_update_window.sv
// -----------------------------------------------------------------------------
// tb_forward_update_window
//
// Directed steps against forward_update_window (DEPTH=2). Each step drives a
// query, pushes the expected registered result, and the result is popped and
// compared one cycle later.
//
// Expected vector layout (19 bits):
//   {updated, hash_adr[1:0], data[3:0], key[1:0], valid, shift_adr[1:0],
//    shift_valid, nm_updated, nm_hash_adr[1:0], nm_valid, occupancy[1:0]}
// -----------------------------------------------------------------------------
module tb_forward_update_window;

    localparam int W = 19;

    logic       clk;
    logic       reset;
    logic       clk_en;
    logic       flush_i;
    logic       wr_en_i;
    logic [1:0] wr_hash_adr_i;
    logic [3:0] wr_data_i;
    logic [1:0] wr_key_i;
    logic       wr_valid_i;
    logic [1:0] wr_shift_adr_i;
    logic       wr_shift_valid_i;
    logic       nm_wr_en_i;
    logic [1:0] nm_wr_adr_i;
    logic       nm_wr_valid_i;
    logic [1:0] query_hash_adr_i;
    logic [1:0] query_shift_adr_i;
    logic [1:0] forward_hash_adr_o;
    logic [3:0] forward_data_o;
    logic [1:0] forward_key_o;
    logic       forward_valid_o;
    logic [1:0] forward_shift_hash_adr_o;
    logic       forward_shift_valid_o;
    logic       forward_updated_mem_o;
    logic [1:0] forward_next_mem_hash_adr_o;
    logic       forward_next_mem_valid_o;
    logic       forward_next_mem_updated_o;
    logic [1:0] occupancy_o;

    forward_update_window #(
        .DATA_WIDTH           (4),
        .KEY_WIDTH            (2),
        .HASH_ADR_WIDTH       (2),
        .SHIFT_HASH_ADR_WIDTH (2),
        .DEPTH                (2)
    ) dut (
        .clk                         (clk),
        .reset                       (reset),
        .clk_en                      (clk_en),
        .flush_i                     (flush_i),
        .wr_en_i                     (wr_en_i),
        .wr_hash_adr_i               (wr_hash_adr_i),
        .wr_data_i                   (wr_data_i),
        .wr_key_i                    (wr_key_i),
        .wr_valid_i                  (wr_valid_i),
        .wr_shift_adr_i              (wr_shift_adr_i),
        .wr_shift_valid_i            (wr_shift_valid_i),
        .nm_wr_en_i                  (nm_wr_en_i),
        .nm_wr_adr_i                 (nm_wr_adr_i),
        .nm_wr_valid_i               (nm_wr_valid_i),
        .query_hash_adr_i            (query_hash_adr_i),
        .query_shift_adr_i           (query_shift_adr_i),
        .forward_hash_adr_o          (forward_hash_adr_o),
        .forward_data_o              (forward_data_o),
        .forward_key_o               (forward_key_o),
        .forward_valid_o             (forward_valid_o),
        .forward_shift_hash_adr_o    (forward_shift_hash_adr_o),
        .forward_shift_valid_o       (forward_shift_valid_o),
        .forward_updated_mem_o       (forward_updated_mem_o),
        .forward_next_mem_hash_adr_o (forward_next_mem_hash_adr_o),
        .forward_next_mem_valid_o    (forward_next_mem_valid_o),
        .forward_next_mem_updated_o  (forward_next_mem_updated_o),
        .occupancy_o                 (occupancy_o)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    string        tag_q[$];
    int           checks   = 0;
    int           failures = 0;
    logic         issued   = 1'b0;

    localparam logic [12:0] OWN_NONE = 13'd0;
    localparam logic [3:0]  NM_NONE  = 4'd0;

    function automatic logic [12:0] own_hit(input logic [1:0] h, input logic [3:0] d,
                                            input logic [1:0] k, input logic v,
                                            input logic [1:0] s, input logic sv);
        return {1'b1, h, d, k, v, s, sv};
    endfunction

    function automatic logic [3:0] nm_hit(input logic [1:0] a, input logic v);
        return {1'b1, a, v};
    endfunction

    function automatic logic [W-1:0] mk(input logic [12:0] own, input logic [3:0] nm,
                                        input logic [1:0] occ);
        return {own, nm, occ};
    endfunction

    function automatic logic [W-1:0] observed();
        return {forward_updated_mem_o, forward_hash_adr_o, forward_data_o, forward_key_o,
                forward_valid_o, forward_shift_hash_adr_o, forward_shift_valid_o,
                forward_next_mem_updated_o, forward_next_mem_hash_adr_o,
                forward_next_mem_valid_o, occupancy_o};
    endfunction

    task automatic check_pop();
        logic [W-1:0] exp;
        logic [W-1:0] obs;
        string        tag;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL scoreboard_underflow observed=empty expected=entry");
        end else begin
            exp = exp_q.pop_front();
            tag = tag_q.pop_front();
            obs = observed();
            checks++;
            assert (obs === exp) else begin
                failures++;
                $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
            end
        end
    endtask

    // ---------------- drivers ----------------
    task automatic drive_wr(input logic [1:0] adr, input logic [3:0] data, input logic [1:0] key,
                            input logic valid, input logic [1:0] shift, input logic sv);
        wr_en_i          = 1'b1;
        wr_hash_adr_i    = adr;
        wr_data_i        = data;
        wr_key_i         = key;
        wr_valid_i       = valid;
        wr_shift_adr_i   = shift;
        wr_shift_valid_i = sv;
    endtask

    task automatic drive_nm(input logic [1:0] adr, input logic valid);
        nm_wr_en_i    = 1'b1;
        nm_wr_adr_i   = adr;
        nm_wr_valid_i = valid;
    endtask

    task automatic query(input logic [1:0] adr, input logic [1:0] shift,
                         input logic [W-1:0] exp, input string tag);
        query_hash_adr_i  = adr;
        query_shift_adr_i = shift;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        issued = 1'b1;
    endtask

    // One clock: results of a query issued this cycle are compared #1 after the edge.
    task automatic tick();
        logic had;
        had = issued;
        @(posedge clk);
        #1;
        issued     = 1'b0;
        wr_en_i    = 1'b0;
        nm_wr_en_i = 1'b0;
        flush_i    = 1'b0;
        wr_hash_adr_i    = 2'($urandom_range(0, 3));
        wr_data_i        = 4'($urandom_range(0, 15));
        nm_wr_adr_i      = 2'($urandom_range(0, 3));
        if (had) check_pop();
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        reset = 1'b1; clk_en = 1'b1; flush_i = 1'b0;
        wr_en_i = 1'b0; wr_hash_adr_i = '0; wr_data_i = '0; wr_key_i = '0; wr_valid_i = 1'b0;
        wr_shift_adr_i = '0; wr_shift_valid_i = 1'b0;
        nm_wr_en_i = 1'b0; nm_wr_adr_i = '0; nm_wr_valid_i = 1'b0;
        query_hash_adr_i = '0; query_shift_adr_i = '0;

        tick();
        tick();
        reset = 1'b0;
        exp_q.push_back(mk(OWN_NONE, NM_NONE, 2'd0));
        tag_q.push_back("reset_state");
        check_pop();

        query(2'd1, 2'd0, mk(OWN_NONE, NM_NONE, 2'd0), "after_reset_query");
        tick();

        drive_wr(2'd2, 4'd5, 2'd1, 1'b1, 2'd3, 1'b1);
        query(2'd0, 2'd0, mk(OWN_NONE, NM_NONE, 2'd1), "first_write_no_match");
        tick();

        query(2'd2, 2'd0, mk(own_hit(2'd2, 4'd5, 2'd1, 1'b1, 2'd3, 1'b1), NM_NONE, 2'd1), "read_adr2");
        tick();

        drive_wr(2'd3, 4'd4, 2'd0, 1'b1, 2'd0, 1'b0);
        query(2'd1, 2'd0, mk(OWN_NONE, NM_NONE, 2'd2), "miss_occ2");
        tick();

        drive_wr(2'd3, 4'd9, 2'd2, 1'b1, 2'd1, 1'b1);
        query(2'd2, 2'd0, mk(own_hit(2'd2, 4'd5, 2'd1, 1'b1, 2'd3, 1'b1), NM_NONE, 2'd2), "oldest_entry_hit");
        tick();

        query(2'd3, 2'd0, mk(own_hit(2'd3, 4'd9, 2'd2, 1'b1, 2'd1, 1'b1), NM_NONE, 2'd2), "youngest_wins");
        tick();

        drive_wr(2'd1, 4'd7, 2'd3, 1'b1, 2'd2, 1'b0);
        query(2'd1, 2'd0, mk(own_hit(2'd1, 4'd7, 2'd3, 1'b1, 2'd2, 1'b0), NM_NONE, 2'd2), "write_bypass");
        tick();

        drive_wr(2'd0, 4'd1, 2'd0, 1'b1, 2'd0, 1'b1);
        query(2'd3, 2'd0, mk(own_hit(2'd3, 4'd9, 2'd2, 1'b1, 2'd1, 1'b1), NM_NONE, 2'd2), "entry1_hit");
        tick();

        drive_wr(2'd1, 4'd2, 2'd1, 1'b0, 2'd0, 1'b0);
        query(2'd1, 2'd0, mk(own_hit(2'd1, 4'd2, 2'd1, 1'b0, 2'd0, 1'b0), NM_NONE, 2'd2), "bypass_deletion");
        tick();

        drive_wr(2'd2, 4'd3, 2'd0, 1'b1, 2'd1, 1'b1);
        query(2'd1, 2'd0, mk(own_hit(2'd1, 4'd2, 2'd1, 1'b0, 2'd0, 1'b0), NM_NONE, 2'd2), "stored_deletion");
        tick();

        query(2'd0, 2'd0, mk(OWN_NONE, NM_NONE, 2'd2), "evicted_adr0");
        tick();

        drive_nm(2'd2, 1'b1);
        query(2'd2, 2'd2, mk(own_hit(2'd2, 4'd3, 2'd0, 1'b1, 2'd1, 1'b1), nm_hit(2'd2, 1'b1), 2'd2), "nm_bypass");
        tick();

        drive_nm(2'd3, 1'b0);
        query(2'd0, 2'd2, mk(OWN_NONE, nm_hit(2'd2, 1'b1), 2'd2), "nm_stored");
        tick();

        drive_nm(2'd2, 1'b0);
        query(2'd0, 2'd2, mk(OWN_NONE, nm_hit(2'd2, 1'b0), 2'd2), "nm_youngest_bypass");
        tick();

        query(2'd3, 2'd3, mk(OWN_NONE, nm_hit(2'd3, 1'b0), 2'd2), "nm_entry1");
        tick();

        drive_nm(2'd1, 1'b1);
        query(2'd0, 2'd2, mk(OWN_NONE, nm_hit(2'd2, 1'b0), 2'd2), "nm_entry0");
        tick();

        query(2'd2, 2'd3, mk(own_hit(2'd2, 4'd3, 2'd0, 1'b1, 2'd1, 1'b1), NM_NONE, 2'd2), "nm_evicted");
        tick();

        // Stage disabled: everything ignored, outputs hold the previous result.
        clk_en = 1'b0;
        flush_i = 1'b1;
        drive_wr(2'd3, 4'd15, 2'd3, 1'b1, 2'd3, 1'b1);
        drive_nm(2'd3, 1'b1);
        query(2'd3, 2'd3, mk(own_hit(2'd2, 4'd3, 2'd0, 1'b1, 2'd1, 1'b1), NM_NONE, 2'd2), "stall_hold");
        tick();
        clk_en = 1'b1;

        query(2'd3, 2'd3, mk(OWN_NONE, NM_NONE, 2'd2), "stall_write_dropped");
        tick();

        query(2'd1, 2'd1, mk(own_hit(2'd1, 4'd2, 2'd1, 1'b0, 2'd0, 1'b0), nm_hit(2'd1, 1'b1), 2'd2), "window_intact");
        tick();

        flush_i = 1'b1;
        drive_wr(2'd1, 4'd6, 2'd2, 1'b1, 2'd2, 1'b1);
        drive_nm(2'd1, 1'b1);
        query(2'd1, 2'd1, mk(OWN_NONE, NM_NONE, 2'd0), "flush_clears");
        tick();

        query(2'd1, 2'd1, mk(OWN_NONE, NM_NONE, 2'd0), "flush_write_dropped");
        tick();

        drive_wr(2'd1, 4'd6, 2'd2, 1'b1, 2'd2, 1'b1);
        query(2'd2, 2'd2, mk(OWN_NONE, NM_NONE, 2'd1), "after_flush_miss");
        tick();

        query(2'd1, 2'd0, mk(own_hit(2'd1, 4'd6, 2'd2, 1'b1, 2'd2, 1'b1), NM_NONE, 2'd1), "after_flush_hit");
        tick();

        // Reset overrides a disabled stage.
        reset = 1'b1;
        clk_en = 1'b0;
        query(2'd1, 2'd0, mk(OWN_NONE, NM_NONE, 2'd0), "reset_while_disabled");
        tick();
        reset = 1'b0;
        clk_en = 1'b1;

        query(2'd1, 2'd1, mk(OWN_NONE, NM_NONE, 2'd0), "post_reset_miss");
        tick();

        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $error("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
